bus_arbiter_rr: RTL and testbench
=================================

// Module: bus_arbiter_rr
// PURPOSE
//  Parametrised DMA bus arbiter; next generation of the bus_control arbiter.
//  Grants the shared address/data bus to one of N masters via one-hot grant.
//  Adds round-robin or fixed priority, burst-limit preemption and a ready-timeout watchdog.
//  Sits between the DMA request lines of all masters and the shared request/ready handshake.
// PARAMETERS
//  N_MASTERS   8    number of DMA masters (2..16)
//  RR_MODE     1    1 = round-robin, 0 = fixed priority (index 0 highest)
//  MAX_BURST   16   completed transfers before preemption if others wait; 0 = never preempt
//  TIMEOUT     255  cycles request may wait for ready before forced release; 0 = disabled
// PORTS
//  clk         in   1          bus clock, all state on rising edge
//  rst_n       in   1          asynchronous, active-low reset
//  DMA         in   N_MASTERS  per-master bus request, level, held while master wants bus
//  grant       out  N_MASTERS  one-hot (or zero) bus grant, registered
//  request     in   1          transfer strobe from granted master
//  ready       in   1          transfer complete from addressed slave
//  owner_id    out  4          index of current owner; valid when bus_busy=1
//  bus_busy    out  1          high while any grant bit is set
//  bus_error   out  1          one-cycle pulse on timeout-forced release
// BEHAVIOUR
//  Reset (async, rst_n=0): grant=0, owner_id=0, bus_busy=0, bus_error=0,
//   state=IDLE, rr pointer=N_MASTERS-1 (so master 0 wins first), counters=0.
//  Transfer completes on any cycle with request=1 && ready=1 (counted once per cycle).
//  FSM states: IDLE, OWNED, DRAIN, TURN.
//   IDLE : if DMA!=0 pick winner; next edge grant[w]=1, owner_id=w, -> OWNED.
//          Latency DMA rise -> grant = 1 cycle.
//   OWNED: DMA[owner] low && request low -> grant=0 next edge, -> TURN.
//          burst_cnt==MAX_BURST && other DMA bits set -> DRAIN.
//          wait_cnt reaches TIMEOUT -> grant=0, bus_error=1 one cycle, -> TURN.
//   DRAIN: grant held until request low or request&&ready seen; then grant=0, -> TURN.
//          Timeout still applies in DRAIN.
//   TURN : exactly one idle cycle, grant=0, -> IDLE (re-arbitrate next cycle).
//  Arbitration: RR_MODE=1 searches from last_owner+1 upward with wrap at N_MASTERS-1
//   -> 0; RR_MODE=0 lowest set index wins. rr pointer updates only on grant.
//  burst_cnt: clears on new grant, +1 per completed transfer, saturates at MAX_BURST.
//  wait_cnt: clears when request=0 or ready=1; +1 each cycle request=1 && ready=0;
//   width ceil(log2(TIMEOUT+1)), saturating.
//  Master dropping DMA mid-transfer (request=1): grant held until transfer ends.
//  DMA bit of a non-owner toggling: no effect until next arbitration.
//  Owner re-asserting DMA in TURN: competes normally; round-robin deprioritises it.
//  grant never has more than one bit set; grant changes only via TURN (no back-to-back
//   owner switch without an idle cycle).
//  rst_n asserted mid-transfer: grant drops immediately (async), state IDLE.
// TESTING
//  1 Reset release, DMA=8'h01 -> grant=8'h01 one cycle later, bus_busy=1, owner_id=0.
//  2 RR_MODE=1, DMA=8'h05 held, each owner drops DMA after 1 transfer -> grants
//    0x01,0x04,0x01,0x04 with one idle cycle between each.
//  3 RR_MODE=0, DMA=8'h06 -> grant=0x02; master 1 releases -> grant=0x04 after TURN.
//  4 MAX_BURST=4, master 0 streams request&&ready, DMA=8'h03 -> grant 0x01 drops
//    after 4th completion, TURN, grant=0x02.
//  5 TIMEOUT=8, owner holds request=1, ready=0 -> bus_error pulse on cycle 8,
//    grant=0, then next requester granted.
//  6 rst_n=0 while grant=0x02 and request=1 -> grant=0, bus_busy=0 without clock edge.

Source files
------------

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: shared-bus arbiter for N DMA masters.
// Grants the bus to one master at a time through a registered one-hot grant.
// The winner is chosen by round-robin or fixed priority. A master that has
// used up its burst allowance is preempted when others are waiting. A
// ready-timeout watchdog forces the bus free. Every release passes through a
// single idle TURN cycle before the next arbitration.
//
// Ports:
//   clk        bus clock, rising edge
//   rst_n      asynchronous active-low reset
//   DMA        per-master level request
//   grant      registered one-hot (or zero) grant
//   request    transfer strobe from the granted master
//   ready      transfer completion from the addressed slave
//   owner_id   index of the current owner (meaningful while bus_busy)
//   bus_busy   any grant bit set
//   bus_error  one-cycle pulse when the watchdog forces a release
module bus_arbiter_rr #(
    parameter int N_MASTERS = 8,
    parameter int RR_MODE   = 1,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_MASTERS-1:0] DMA,
    output logic [N_MASTERS-1:0] grant,
    input  logic                 request,
    input  logic                 ready,
    output logic [3:0]           owner_id,
    output logic                 bus_busy,
    output logic                 bus_error
);

    localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(TIMEOUT);
    localparam logic [WW-1:0] WAIT_LAST = (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;
    localparam logic [N_MASTERS-1:0] ONE   = 1;
    localparam logic [N_MASTERS:0]   ONE_W = 1;

    typedef enum logic [1:0] {S_IDLE, S_OWNED, S_DRAIN, S_TURN} state_t;

    state_t               state_q, state_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [3:0]           owner_q, owner_d;
    logic [3:0]           rr_q, rr_d;
    logic [BW-1:0]        burst_q, burst_d;
    logic [WW-1:0]        wait_q, wait_d;
    logic                 err_q, err_d;

    function automatic logic [3:0] lowest(input logic [N_MASTERS-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Round-robin: requests strictly above the last owner win first; if none,
    // wrap around to the lowest requester. upto has bits [rr:0] set.
    logic [N_MASTERS:0]   upto;
    logic [N_MASTERS-1:0] hi_req;
    logic [3:0]           winner;

    always_comb begin
        upto   = (ONE_W << ({1'b0, rr_q} + 5'd1)) - ONE_W;
        hi_req = DMA & ~upto[N_MASTERS-1:0];
        if (RR_MODE != 0 && hi_req != '0) winner = lowest(hi_req);
        else                              winner = lowest(DMA);
    end

    logic xfer, stall, owner_req, others, in_bus, timeout_hit;

    assign xfer        = request && ready;
    assign stall       = request && !ready;
    // Owner's own DMA bit and "anyone else waiting", without indexing by owner.
    assign owner_req   = |(DMA & grant_q);
    assign others      = |(DMA & ~grant_q);
    assign in_bus      = (state_q == S_OWNED) || (state_q == S_DRAIN);
    // Fires on the TIMEOUT-th consecutive stalled cycle.
    assign timeout_hit = (TIMEOUT > 0) && stall && (wait_q == WAIT_LAST);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        burst_d = burst_q;
        wait_d  = '0;
        err_d   = 1'b0;

        if (in_bus) begin
            if (stall) wait_d = (wait_q != WAIT_MAX) ? wait_q + 1'b1 : wait_q;
            if (xfer && burst_q != BURST_MAX) burst_d = burst_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (DMA != '0) begin
                    grant_d = ONE << winner;
                    owner_d = winner;
                    rr_d    = winner;
                    burst_d = '0;
                    state_d = S_OWNED;
                end
            end
            S_OWNED: begin
                if (timeout_hit) begin
                    grant_d = '0;
                    err_d   = 1'b1;
                    state_d = S_TURN;
                end else if (!owner_req && !request) begin
                    grant_d = '0;
                    state_d = S_TURN;
                end else if (MAX_BURST > 0 && others && burst_d == BURST_MAX) begin
                    // Allowance used up this cycle or earlier: let the
                    // in-flight transfer finish, then hand over.
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (timeout_hit) begin
                    grant_d = '0;
                    err_d   = 1'b1;
                    state_d = S_TURN;
                end else if (!request || xfer) begin
                    grant_d = '0;
                    state_d = S_TURN;
                end
            end
            S_TURN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            rr_q    <= 4'(N_MASTERS - 1);
            burst_q <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            burst_q <= burst_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    assign grant     = grant_q;
    assign owner_id  = owner_q;
    assign bus_busy  = |grant_q;
    assign bus_error = err_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr. Two instances share one stimulus stream:
//   inst 0: round-robin, MAX_BURST=4, TIMEOUT=8
//   inst 1: fixed priority, no preemption, no watchdog
// A per-instance behavioural model is compared with both instances on every
// falling edge. Literal expectations at key points pin the model.
module tb_bus_arbiter_rr;
    localparam int NM = 8;
    localparam int MODE[2] = '{1, 0};
    localparam int MB[2]   = '{4, 0};
    localparam int TO[2]   = '{8, 0};

    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] dma = '0;
    logic req = 1'b0, rdy = 1'b0;
    logic [7:0] g_rr, g_fp;
    logic [3:0] o_rr, o_fp;
    logic b_rr, b_fp, e_rr, e_fp;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bus_arbiter_rr #(.N_MASTERS(NM), .RR_MODE(1), .MAX_BURST(4), .TIMEOUT(8)) u_rr (
        .clk(clk), .rst_n(rst_n), .DMA(dma), .grant(g_rr), .request(req), .ready(rdy),
        .owner_id(o_rr), .bus_busy(b_rr), .bus_error(e_rr));

    bus_arbiter_rr #(.N_MASTERS(NM), .RR_MODE(0), .MAX_BURST(0), .TIMEOUT(0)) u_fp (
        .clk(clk), .rst_n(rst_n), .DMA(dma), .grant(g_fp), .request(req), .ready(rdy),
        .owner_id(o_fp), .bus_busy(b_fp), .bus_error(e_fp));

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 owned, 2 draining, 3 turn
    int       mph[2]   = '{0, 0};
    int       mown[2]  = '{0, 0};
    int       mlast[2] = '{NM - 1, NM - 1};
    int       mburst[2] = '{0, 0};
    int       mstall[2] = '{0, 0};
    logic [7:0] mg[2]  = '{8'h00, 8'h00};
    logic     merr[2]  = '{1'b0, 1'b0};

    function automatic int pick(input int m, input logic [7:0] d);
        if (MODE[m] != 0) begin
            for (int k = 1; k <= NM; k++) begin
                int idx = (mlast[m] + k) % NM;
                if (((d >> idx) & 8'h01) != 0) return idx;
            end
        end else begin
            for (int i = 0; i < NM; i++)
                if (((d >> i) & 8'h01) != 0) return i;
        end
        return 0;
    endfunction

    task automatic step(input int m);
        bit xf, to, odma, oth;
        int w;
        merr[m] = 1'b0;
        xf = req && rdy;
        case (mph[m])
            0: if (dma != 0) begin
                w = pick(m, dma);
                mown[m] = w; mlast[m] = w;
                mg[m] = 8'h01 << w;
                mburst[m] = 0; mstall[m] = 0;
                mph[m] = 1;
            end
            1, 2: begin
                mstall[m] = (req && !rdy) ? mstall[m] + 1 : 0;
                mburst[m] = mburst[m] + int'(xf);
                odma = (dma & mg[m]) != 0;
                oth  = (dma & ~mg[m]) != 0;
                to   = TO[m] > 0 && mstall[m] >= TO[m];
                if (to) begin
                    merr[m] = 1'b1; mg[m] = 0; mph[m] = 3;
                end else if (mph[m] == 1) begin
                    if (!odma && !req) begin mg[m] = 0; mph[m] = 3; end
                    else if (MB[m] > 0 && mburst[m] >= MB[m] && oth) mph[m] = 2;
                end else if (!req || xf) begin
                    mg[m] = 0; mph[m] = 3;
                end
            end
            default: mph[m] = 0;
        endcase
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
                mph[m] = 0; mown[m] = 0; mlast[m] = NM - 1;
                mburst[m] = 0; mstall[m] = 0; mg[m] = 0; merr[m] = 1'b0;
            end else begin
                step(m);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        chk("cmp_grant0", int'(g_rr), int'(mg[0]));
        chk("cmp_busy0",  int'(b_rr), int'(mg[0] != 0));
        chk("cmp_err0",   int'(e_rr), int'(merr[0]));
        if (mg[0] != 0) chk("cmp_owner0", int'(o_rr), mown[0]);
        chk("cmp_grant1", int'(g_fp), int'(mg[1]));
        chk("cmp_busy1",  int'(b_fp), int'(mg[1] != 0));
        chk("cmp_err1",   int'(e_fp), int'(merr[1]));
        if (mg[1] != 0) chk("cmp_owner1", int'(o_fp), mown[1]);
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic [7:0] d, input logic r, input logic y);
        dma = d; req = r; rdy = y;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; dma = '0; req = 1'b0; rdy = 1'b0;
        @(posedge clk); #1;
        chk("rst_grant", int'(g_rr | g_fp), 0);
        chk("rst_owner", int'({o_rr, o_fp}), 0);
        chk("rst_busy",  int'(b_rr | b_fp), 0);
        chk("rst_err",   int'(e_rr | e_fp), 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    logic [7:0] exp_g[4] = '{8'h01, 8'h04, 8'h01, 8'h04};

    initial begin
        rst_n = 1'b0;
        // 1: first grant after reset goes to master 0, one cycle after DMA
        do_reset();
        cyc(8'h01, 0, 0);
        chk("t1_grant", int'(g_rr), 8'h01);
        chk("t1_busy",  int'(b_rr), 1);
        chk("t1_owner", int'(o_rr), 0);

        // 2: round-robin alternation with an idle cycle between owners
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(8'h05, 0, 0);
            chk("t2_grant", int'(g_rr), int'(exp_g[i]));
            cyc(8'h05, 1, 1);
            cyc(8'h05 & ~exp_g[i], 0, 0);
            chk("t2_turn", int'(g_rr), 0);
            cyc(8'h05, 0, 0);
        end

        // 3: fixed priority, non-owner toggling, DMA drop mid-transfer
        do_reset();
        cyc(8'h06, 0, 0);
        chk("t3_grant1", int'(g_fp), 8'h02);
        cyc(8'h06, 1, 1);
        cyc(8'h04, 0, 0);
        chk("t3_turn", int'(g_fp), 0);
        cyc(8'h04, 0, 0);
        cyc(8'h04, 0, 0);
        chk("t3_grant2", int'(g_fp), 8'h04);
        cyc(8'h05, 0, 0);
        chk("t3_hold", int'(g_fp), 8'h04);
        cyc(8'h01, 0, 0);
        cyc(8'h01, 0, 0);
        cyc(8'h01, 0, 0);
        chk("t3_grant0", int'(g_fp), 8'h01);
        cyc(8'h00, 1, 0);
        chk("t3_midxfer", int'(g_fp), 8'h01);
        cyc(8'h00, 1, 1);
        cyc(8'h00, 0, 0);
        chk("t3_release", int'(g_fp), 0);

        // 4: burst-limit preemption after the 4th completion
        do_reset();
        cyc(8'h03, 0, 0);
        for (int i = 0; i < 4; i++) cyc(8'h03, 1, 1);
        chk("t4_drain_hold", int'(g_rr), 8'h01);
        cyc(8'h03, 0, 0);
        chk("t4_drop", int'(g_rr), 0);
        cyc(8'h03, 0, 0);
        cyc(8'h03, 0, 0);
        chk("t4_next", int'(g_rr), 8'h02);
        chk("t4_nopreempt", int'(g_fp), 8'h01);

        // 5: ready timeout on the 8th stalled cycle
        do_reset();
        cyc(8'h03, 0, 0);
        for (int i = 0; i < 7; i++) cyc(8'h03, 1, 0);
        chk("t5_pre_grant", int'(g_rr), 8'h01);
        chk("t5_pre_err",   int'(e_rr), 0);
        cyc(8'h03, 1, 0);
        chk("t5_err",   int'(e_rr), 1);
        chk("t5_grant", int'(g_rr), 0);
        cyc(8'h03, 0, 0);
        chk("t5_err_pulse", int'(e_rr), 0);
        cyc(8'h03, 0, 0);
        chk("t5_next", int'(g_rr), 8'h02);
        chk("t5_fp_noerr", int'(g_fp), 8'h01);

        // 6: asynchronous reset mid-transfer
        cyc(8'h03, 1, 0);
        chk("t6_pre", int'(g_rr), 8'h02);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_grant", int'(g_rr), 0);
        chk("t6_busy",  int'(b_rr), 0);
        chk("t6_owner", int'(o_rr), 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        cyc(8'h81, 0, 0);
        chk("t6_after", int'(g_rr), 8'h01);
        cyc(8'h00, 0, 0);
        cyc(8'h00, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
